brick_field: RTL and testbench
==============================

BRICK_FIELD -- requirements
Module: brick_field

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, the number of brick rows (1..16).
REQ-002 The block SHALL have parameter COLS, default 16, the number of brick columns (1..32).
REQ-003 The block SHALL have parameter HP_W, default 2, the hit-point width; HP_MAX = 2**HP_W-1.
REQ-004 The block SHALL have parameter SCORE_W, default 16, the score width.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, the reset, asynchronous and active-low.
REQ-007 The block SHALL have port load, input, 1, a one-cycle request to (re)build the field.
REQ-008 The block SHALL have port level, input, 3, the pattern selector, sampled with load.
REQ-009 The block SHALL have ports hit_valid (input, 1), hit_row (input, 4) and hit_col (input, 5), the collision request.
REQ-010 The block SHALL have port hit_ready, output, 1, set when a hit is accepted this cycle.
REQ-011 The block SHALL have ports hit_done (output, 1), a one-cycle response pulse, hit_destroyed (output, 1) and hit_empty (output, 1).
REQ-012 The block SHALL have ports rd_row (input, 4), rd_col (input, 5) and rd_hp (output, HP_W), the render read port.
REQ-013 The block SHALL have ports remaining (output, 10), the live brick count, score (output, SCORE_W), busy (output, 1) set while loading, and win (output, 1), a one-cycle pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, PLAY and CLEARED.
REQ-015 load in any state SHALL latch level, zero remaining and go to LOAD with index 0, so that a load mid-LOAD restarts from index 0.
REQ-016 LOAD SHALL write one brick per cycle at index = row*COLS+col and take exactly ROWS*COLS cycles; it then enters PLAY, or CLEARED if remaining=0, with win asserted in the CLEARED case.
REQ-017 The pattern SHALL be hp = ((row+level) mod HP_MAX)+1.
REQ-018 The pattern SHALL force hp to 0 when level[0]=1 and (row+col) is odd.
REQ-019 LOAD SHALL increment remaining for each nonzero brick written.
REQ-020 hit_ready SHALL equal (state==PLAY) && !load; a hit is accepted when hit_valid && hit_ready.
REQ-021 hit_done SHALL pulse exactly one cycle after acceptance, with the addressed brick already updated.
REQ-022 A hit on an out-of-range coordinate or a zero-hp brick SHALL give hit_empty=1 and hit_destroyed=0, with no state change.
REQ-023 A hit on a nonzero brick SHALL decrement hp by 1 and add 1 to score; if hp becomes 0 it SHALL also give hit_destroyed=1, add 4 more to score and decrement remaining.
REQ-024 score SHALL saturate at 2**SCORE_W-1 and never wrap.
REQ-025 score SHALL be cleared only by reset, not by load.
REQ-026 When a hit decrements remaining 1->0, the block SHALL go to CLEARED and pulse win in the same cycle as hit_done.
REQ-027 CLEARED SHALL be left only via load.
REQ-028 When load and hit_valid are high together, load SHALL win, the hit SHALL be dropped and no hit_done SHALL occur.
REQ-029 rd_hp SHALL be registered with 1-cycle latency and SHALL return 0 for out-of-range coordinates.
REQ-030 rd_hp SHALL show the field as it stands, including bricks partly written during LOAD.
REQ-031 A hit and a render read of the same brick in the same cycle SHALL return the pre-hit hp.
REQ-032 busy SHALL be 1 exactly while in LOAD.

Reset
REQ-033 On rst low, the block SHALL asynchronously go to IDLE with all hp=0 and remaining=0.
REQ-034 On rst low, score=0, rd_hp=0, and hit_done, hit_destroyed, hit_empty, win and busy SHALL all be 0.
REQ-035 hit_ready SHALL be 0 in IDLE.
REQ-036 Reset during LOAD or with a hit pending SHALL abandon the operation with no hit_done or win afterwards.

Structure
REQ-037 A shared package brick_pkg SHALL hold the FSM state enum, the score increments (HIT_PTS=1, DESTROY_BONUS=4) and the hp/level widths.
REQ-038 The pattern SHALL live in one combinational sub-module, brick_pattern (level, row, col -> hp), reusable by a future level editor.

Verification
REQ-039 Load at level=0 with defaults -> busy high for 64 cycles, remaining=64, rd_hp(2,5)=3, rd_hp(0,0)=1.
REQ-040 Load at level=1 -> remaining=32 and rd_hp(0,1)=0.
REQ-041 Load at level=1, then hit (0,1) -> hit_empty=1 and score unchanged.
REQ-042 Level 0, hit (0,0) once -> hit_done next cycle with hit_destroyed=1, remaining=63, score=5.
REQ-043 Level 0, hit (1,0) twice -> first hit gives score+1, second gives hit_destroyed=1.
REQ-044 Load with ROWS=1, COLS=1, then hit (0,0) -> win pulses with hit_done and the state is CLEARED.
REQ-045 Then a further hit_valid -> hit_ready=0.
REQ-046 load and hit_valid in the same cycle -> no hit_done and busy=1.
REQ-047 rst low at load cycle 10 -> all outputs 0 immediately.
REQ-048 Force score to 65534, then destroy a brick -> score=65535.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared types and constants for the brick field.
// Imported by the pattern generator and the field top.
package brick_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_LOAD    = 2'd1;
  localparam state_t S_PLAY    = 2'd2;
  localparam state_t S_CLEARED = 2'd3;

  localparam int HIT_PTS       = 1;
  localparam int DESTROY_BONUS = 4;

  localparam int LEVEL_W  = 3;
  localparam int ROW_W    = 4;
  localparam int COL_W    = 5;
  localparam int REM_W    = 10;
  localparam int HP_W_DEF = 2;

endpackage

// File: rtl/brick_pattern.sv
// Level pattern: starting hit points of one brick.
// Purely combinational so a level editor can reuse it.
module brick_pattern
  import brick_pkg::*;
#(
  parameter int HP_W = HP_W_DEF
) (
  input  logic [LEVEL_W-1:0] level_i,
  input  logic [ROW_W-1:0]   row_i,
  input  logic [COL_W-1:0]   col_i,
  output logic [HP_W-1:0]    hp_o
);

  localparam int HP_MAX = 2**HP_W - 1;

  logic [5:0] sum;
  logic [5:0] rem;

  always_comb begin
    sum  = 6'(row_i) + 6'(level_i);
    rem  = sum % 6'(HP_MAX);
    hp_o = HP_W'(rem) + HP_W'(1);
    // odd levels punch a checkerboard of holes
    if (level_i[0] && (row_i[0] ^ col_i[0]))
      hp_o = '0;
  end

endmodule

// File: rtl/brick_field.sv
// Brick field: pattern load, hit resolution, scoring and render read port.
// One brick is written per cycle while loading; hits resolve in one cycle.
module brick_field
  import brick_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 16,
  parameter int HP_W    = 2,
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [2:0]         level,
  input  logic               hit_valid,
  input  logic [3:0]         hit_row,
  input  logic [4:0]         hit_col,
  output logic               hit_ready,
  output logic               hit_done,
  output logic               hit_destroyed,
  output logic               hit_empty,
  input  logic [3:0]         rd_row,
  input  logic [4:0]         rd_col,
  output logic [HP_W-1:0]    rd_hp,
  output logic [9:0]         remaining,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               win
);

  localparam int N  = ROWS * COLS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  localparam logic [ROW_W:0]   ROWS_L = (ROW_W+1)'(ROWS);
  localparam logic [COL_W:0]   COLS_L = (COL_W+1)'(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [REM_W-1:0] IDX_LAST = REM_W'(N - 1);

  logic [HP_W-1:0]    field_q [N];

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [REM_W-1:0]   ld_idx_q, ld_idx_d;
  logic [ROW_W-1:0]   ld_row_q, ld_row_d;
  logic [COL_W-1:0]   ld_col_q, ld_col_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [HP_W-1:0]    rd_hp_q;
  logic               done_q, done_d;
  logic               destr_q, destr_d;
  logic               empty_q, empty_d;
  logic               win_q, win_d;

  logic [HP_W-1:0]    pat_hp;
  logic [REM_W-1:0]   hidx, ridx;
  logic               hit_inr, rd_inr;
  logic [HP_W-1:0]    hit_cur;
  logic               hit_live, hit_kill;
  logic               acc, ld_last;
  logic [SCORE_W:0]   score_sum;
  logic               wr_en;
  logic [AW-1:0]      wr_idx;
  logic [HP_W-1:0]    wr_hp;

  brick_pattern #(
    .HP_W(HP_W)
  ) u_pattern (
    .level_i(level_q),
    .row_i  (ld_row_q),
    .col_i  (ld_col_q),
    .hp_o   (pat_hp)
  );

  always_comb begin
    hidx = REM_W'(hit_row) * REM_W'(COLS) + REM_W'(hit_col);
    ridx = REM_W'(rd_row) * REM_W'(COLS) + REM_W'(rd_col);
    hit_inr = ({1'b0, hit_row} < ROWS_L)
           && ({1'b0, hit_col} < COLS_L);
    rd_inr  = ({1'b0, rd_row} < ROWS_L)
           && ({1'b0, rd_col} < COLS_L);
    hit_cur  = hit_inr ? field_q[hidx[AW-1:0]] : '0;
    hit_live = hit_cur != '0;
    hit_kill = hit_cur == HP_W'(1);
    hit_ready = (state_q == S_PLAY) && !load;
    acc       = hit_valid && hit_ready;
    ld_last   = ld_idx_q == IDX_LAST;
    score_sum = {1'b0, score_q}
              + (SCORE_W+1)'(hit_kill ? HIT_PTS + DESTROY_BONUS
                                      : HIT_PTS);
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    ld_idx_d = ld_idx_q;
    ld_row_d = ld_row_q;
    ld_col_d = ld_col_q;
    rem_d    = rem_q;
    score_d  = score_q;
    done_d   = 1'b0;
    destr_d  = 1'b0;
    empty_d  = 1'b0;
    win_d    = 1'b0;
    if (load) begin
      state_d  = S_LOAD;
      level_d  = level;
      ld_idx_d = '0;
      ld_row_d = '0;
      ld_col_d = '0;
      rem_d    = '0;
    end else if (state_q == S_LOAD) begin
      rem_d = rem_q + REM_W'(pat_hp != '0);
      if (ld_last) begin
        state_d = (rem_d == '0) ? S_CLEARED : S_PLAY;
        win_d   = rem_d == '0;
      end else begin
        ld_idx_d = ld_idx_q + REM_W'(1);
        if (ld_col_q == COL_LAST) begin
          ld_col_d = '0;
          ld_row_d = ld_row_q + ROW_W'(1);
        end else begin
          ld_col_d = ld_col_q + COL_W'(1);
        end
      end
    end else if (acc) begin
      done_d  = 1'b1;
      empty_d = !hit_live;
      if (hit_live) begin
        score_d = score_sum[SCORE_W] ? '1
                                     : score_sum[SCORE_W-1:0];
        if (hit_kill) begin
          destr_d = 1'b1;
          rem_d   = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = S_CLEARED;
            win_d   = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = hidx[AW-1:0];
    wr_hp  = hit_cur - HP_W'(1);
    if (!load && state_q == S_LOAD) begin
      wr_en  = 1'b1;
      wr_idx = ld_idx_q[AW-1:0];
      wr_hp  = pat_hp;
    end else if (acc && hit_live) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)
        field_q[i] <= '0;
    end else if (wr_en) begin
      field_q[wr_idx] <= wr_hp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      ld_idx_q <= '0;
      ld_row_q <= '0;
      ld_col_q <= '0;
      rem_q    <= '0;
      score_q  <= '0;
      rd_hp_q  <= '0;
      done_q   <= 1'b0;
      destr_q  <= 1'b0;
      empty_q  <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      ld_idx_q <= ld_idx_d;
      ld_row_q <= ld_row_d;
      ld_col_q <= ld_col_d;
      rem_q    <= rem_d;
      score_q  <= score_d;
      rd_hp_q  <= rd_inr ? field_q[ridx[AW-1:0]] : '0;
      done_q   <= done_d;
      destr_q  <= destr_d;
      empty_q  <= empty_d;
      win_q    <= win_d;
    end
  end

  assign hit_done      = done_q;
  assign hit_destroyed = destr_q;
  assign hit_empty     = empty_q;
  assign rd_hp         = rd_hp_q;
  assign remaining     = rem_q;
  assign score         = score_q;
  assign busy          = state_q == S_LOAD;
  assign win           = win_q;

endmodule

// File: tb/tb_brick_field.sv
// Self-checking bench for brick_field against a behavioural field model.
// Directed steps, a random phase and a saturation grind in one sequence.
module tb_brick_field;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [2:0]  level;
  logic        hv;
  logic [3:0]  hr;
  logic [4:0]  hc;
  logic [3:0]  rdr;
  logic [4:0]  rdc;
  logic        hit_ready, hit_done, hit_destroyed, hit_empty;
  logic [1:0]  rd_hp;
  logic [9:0]  remaining;
  logic [15:0] score;
  logic        busy, win;

  logic        s_load;
  logic        s_hv;
  logic        s_ready, s_done, s_destr, s_empty;
  logic [1:0]  s_rd_hp;
  logic [9:0]  s_rem;
  logic [15:0] s_score;
  logic        s_busy, s_win;

  always #5 clk = ~clk;

  brick_field #(
    .ROWS(4), .COLS(16), .HP_W(2), .SCORE_W(16)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .level(level),
    .hit_valid(hv), .hit_row(hr), .hit_col(hc),
    .hit_ready(hit_ready), .hit_done(hit_done),
    .hit_destroyed(hit_destroyed), .hit_empty(hit_empty),
    .rd_row(rdr), .rd_col(rdc), .rd_hp(rd_hp),
    .remaining(remaining), .score(score),
    .busy(busy), .win(win)
  );

  brick_field #(
    .ROWS(1), .COLS(1), .HP_W(2), .SCORE_W(16)
  ) dut1 (
    .clk(clk), .rst(rst), .load(s_load), .level(3'd0),
    .hit_valid(s_hv), .hit_row(4'd0), .hit_col(5'd0),
    .hit_ready(s_ready), .hit_done(s_done),
    .hit_destroyed(s_destr), .hit_empty(s_empty),
    .rd_row(4'd0), .rd_col(5'd0), .rd_hp(s_rd_hp),
    .remaining(s_rem), .score(s_score),
    .busy(s_busy), .win(s_win)
  );

  int checks = 0;
  int errors = 0;

  int  exp_hp [4][16];
  int  exp_rem;
  int  exp_score;
  bit  exp_play;
  bit  sat_seen;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int pat(int lvl, int r, int c);
    if ((lvl % 2) == 1 && ((r + c) % 2) == 1)
      return 0;
    return ((r + lvl) % 3) + 1;
  endfunction

  function automatic bit inr(int r, int c);
    return r < 4 && c < 16;
  endfunction

  task automatic model_load(int lvl);
    exp_rem = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++) begin
        exp_hp[r][c] = pat(lvl, r, c);
        if (exp_hp[r][c] != 0) exp_rem++;
      end
    exp_play = exp_rem != 0;
  endtask

  task automatic finish_load(int lvl, int already);
    int n;
    n = already;
    while (busy && n < 200) begin
      tick;
      n++;
    end
    chk("load_cycles", n, 64);
    model_load(lvl);
    chk("load_remaining", remaining, exp_rem);
    chk("load_busy_off", busy, 0);
  endtask

  task automatic do_load(int lvl);
    load  = 1'b1;
    level = 3'(lvl);
    tick;
    load = 1'b0;
    chk("load_busy_on", busy, 1);
    finish_load(lvl, 0);
  endtask

  task automatic do_read(int r, int c, int exp);
    rdr = 4'(r);
    rdc = 5'(c);
    tick;
    chk("rd_hp", rd_hp, exp);
  endtask

  task automatic do_hit(int r, int c, int rr, int rc);
    int  e_rd;
    bit  e_des, e_emp, e_win;
    int  inc;
    hv  = 1'b1;
    hr  = 4'(r);
    hc  = 5'(c);
    rdr = 4'(rr);
    rdc = 5'(rc);
    chk("hit_ready", hit_ready, 1);
    e_rd  = inr(rr, rc) ? exp_hp[rr][rc] : 0;
    e_des = 0;
    e_emp = 0;
    e_win = 0;
    if (!inr(r, c) || exp_hp[r][c] == 0) begin
      e_emp = 1;
    end else begin
      exp_hp[r][c]--;
      inc = 1;
      if (exp_hp[r][c] == 0) begin
        e_des = 1;
        inc = 5;
        exp_rem--;
        if (exp_rem == 0) begin
          e_win = 1;
          exp_play = 0;
        end
      end
      if (exp_score + inc > 65535) begin
        exp_score = 65535;
        sat_seen = 1;
      end else begin
        exp_score += inc;
      end
    end
    tick;
    hv = 1'b0;
    chk("hit_done", hit_done, 1);
    chk("hit_destroyed", hit_destroyed, e_des);
    chk("hit_empty", hit_empty, e_emp);
    chk("hit_remaining", remaining, exp_rem);
    chk("hit_score", score, exp_score);
    chk("hit_win", win, e_win);
    chk("hit_rd_pre", rd_hp, e_rd);
    if (e_win) begin
      hv = 1'b1;
      chk("cleared_ready", hit_ready, 0);
      hv = 1'b0;
    end
  endtask

  initial begin
    int s0;
    rst    = 1'b0;
    load   = 1'b0;
    level  = 3'd0;
    hv     = 1'b0;
    hr     = '0;
    hc     = '0;
    rdr    = '0;
    rdc    = '0;
    s_load = 1'b0;
    s_hv   = 1'b0;
    exp_score = 0;
    sat_seen  = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++)
        exp_hp[r][c] = 0;
    exp_rem  = 0;
    exp_play = 0;

    #3;
    chk("rst_score", score, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", hit_done, 0);
    chk("rst_win", win, 0);
    chk("rst_rd_hp", rd_hp, 0);
    chk("idle_ready", hit_ready, 0);
    rst = 1'b1;
    tick;

    do_load(0);
    do_read(2, 5, 3);
    do_read(0, 0, 1);
    do_read(5, 0, 0);
    do_read(1, 20, 0);

    do_hit(0, 0, 0, 0);
    chk("l0_destroy_rem", remaining, 63);
    chk("l0_destroy_score", score, 5);
    do_hit(1, 0, 1, 0);
    chk("l0_first_score", score, 6);
    do_hit(1, 0, 1, 0);
    chk("l0_second_destr", hit_destroyed, 1);

    do_load(1);
    chk("l1_remaining", remaining, 32);
    do_read(0, 1, 0);
    s0 = exp_score;
    do_hit(0, 1, 0, 1);
    chk("l1_empty_score", score, s0);
    do_hit(6, 3, 0, 0);

    // load and hit together: load wins
    load  = 1'b1;
    level = 3'd0;
    hv    = 1'b1;
    hr    = 4'd0;
    hc    = 5'd0;
    tick;
    load = 1'b0;
    hv   = 1'b0;
    chk("lh_no_done", hit_done, 0);
    chk("lh_busy", busy, 1);
    chk("lh_score", score, exp_score);
    finish_load(0, 0);

    // restart mid-load
    load  = 1'b1;
    level = 3'd2;
    tick;
    load = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    load  = 1'b1;
    level = 3'd3;
    tick;
    load = 1'b0;
    finish_load(3, 0);
    do_read(1, 2, pat(3, 1, 2));

    for (int i = 0; i < 300; i++) begin
      if (!exp_play)
        do_load($urandom_range(0, 7));
      else
        do_hit($urandom_range(0, 5), $urandom_range(0, 17),
               $urandom_range(0, 5), $urandom_range(0, 17));
    end

    // reset in the middle of a load
    load  = 1'b1;
    level = 3'd0;
    tick;
    load = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rem", remaining, 0);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_done", hit_done, 0);
    chk("mid_rst_win", win, 0);
    chk("mid_rst_rd", rd_hp, 0);
    chk("mid_rst_ready", hit_ready, 0);
    rst = 1'b1;
    exp_score = 0;
    model_load(0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++)
        exp_hp[r][c] = 0;
    exp_rem  = 0;
    exp_play = 0;
    do_read(0, 0, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_win", win, 0);

    s_load = 1'b1;
    tick;
    s_load = 1'b0;
    chk("s_busy_on", s_busy, 1);
    tick;
    chk("s_busy_off", s_busy, 0);
    chk("s_rem", s_rem, 1);
    s_hv = 1'b1;
    chk("s_ready", s_ready, 1);
    tick;
    chk("s_done", s_done, 1);
    chk("s_win", s_win, 1);
    chk("s_destr", s_destr, 1);
    chk("s_rem0", s_rem, 0);
    chk("s_cleared_ready", s_ready, 0);
    tick;
    chk("s_no_done", s_done, 0);
    chk("s_win_pulse", s_win, 0);
    s_hv = 1'b0;

    for (int round = 0; round < 300 && !sat_seen; round++) begin
      do_load(0);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 16; c++)
          while (exp_hp[r][c] > 0)
            do_hit(r, c, r, c);
    end
    chk("sat_reached", sat_seen, 1);
    chk("sat_score", score, 65535);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
